pacman_game_ctrl: RTL and testbench

Top-level game sequencer for the Pacman datapath. It runs the game state machine (init / play / win / lose) and generates the prescaled movement step strobe. It also qualifies the player's direction buttons into a single registered move command per step, and drives the position-reset request to the movement datapath. It sits between the board inputs (buttons, start/ack) and the movement/score blocks.

---
 rtl/pacman_pkg.sv | 22 ++
 rtl/pacman_step_prescaler.sv | 37 +++
 rtl/pacman_game_ctrl.sv | 126 ++++++++++++
 tb/tb_pacman_game_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and defaults for the Pacman game datapath.
// Game state and move direction encodings are used across blocks.
package pacman_pkg;

    localparam int DEF_TICK_DIV  = 10000;
    localparam int DEF_WIN_SCORE = 30;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_L = 2'b00,
        DIR_U = 2'b01,
        DIR_R = 2'b10,
        DIR_D = 2'b11
    } dir_t;

endpackage

// File: rtl/pacman_step_prescaler.sv
// Movement step prescaler.
// Counts while enabled and emits a wrap strobe every TICK_DIV cycles.
module pacman_step_prescaler
    import pacman_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int CNT_W    = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign wrap = enable && !clear && (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pacman_game_ctrl.sv
// Pacman game sequencer: INIT/PLAY/WIN/LOSE FSM, step strobe
// generation and single-button move qualification.
module pacman_game_ctrl
    import pacman_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int WIN_SCORE = DEF_WIN_SCORE,
    parameter int CNT_W     = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    input  logic        Left,
    input  logic        Right,
    input  logic        Up,
    input  logic        Down,
    input  logic [15:0] score,
    input  logic        hit,
    output logic        move_en,
    output logic [1:0]  dir,
    output logic        step_tick,
    output logic        pos_reset,
    output logic [1:0]  state,
    output logic        win,
    output logic        lose
);

    game_state_t state_q, state_d;
    dir_t        dir_q, dir_d, btn_dir;
    logic        move_en_q, move_en_d;
    logic        step_tick_q, step_tick_d;
    logic        pos_reset_q, pos_reset_d;
    logic        win_q, win_d;
    logic        lose_q, lose_d;
    logic        score_won, btn_one, wrap;
    logic        in_play, stay_play;

    assign score_won = (score >= 16'(WIN_SCORE));
    assign in_play   = (state_q == ST_PLAY);
    assign stay_play = (state_d == ST_PLAY);
    assign btn_one   = $onehot({Left, Up, Right, Down});

    // Counting stops on the exit edge, so a coincident wrap never strobes.
    pacman_step_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .enable (in_play),
        .clear  (!(in_play && stay_play)),
        .wrap   (wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (start) state_d = ST_PLAY;
            ST_PLAY: begin
                if (score_won) begin
                    state_d = ST_WIN;
                end else if (hit) begin
                    state_d = ST_LOSE;
                end
            end
            ST_WIN:  if (ack) state_d = ST_INIT;
            ST_LOSE: if (ack) state_d = ST_INIT;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        btn_dir = DIR_L;
        case (1'b1)
            Up:      btn_dir = DIR_U;
            Right:   btn_dir = DIR_R;
            Down:    btn_dir = DIR_D;
            default: btn_dir = DIR_L;
        endcase
    end

    always_comb begin
        pos_reset_d = (state_d == ST_INIT);
        win_d       = (state_d == ST_WIN);
        lose_d      = (state_d == ST_LOSE);
        step_tick_d = wrap;
        move_en_d   = wrap && btn_one;
        dir_d       = move_en_d ? btn_dir : dir_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_en_q   <= 1'b0;
            step_tick_q <= 1'b0;
            dir_q       <= DIR_L;
            pos_reset_q <= 1'b1;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            move_en_q   <= move_en_d;
            step_tick_q <= step_tick_d;
            dir_q       <= dir_d;
            pos_reset_q <= pos_reset_d;
            win_q       <= win_d;
            lose_q      <= lose_d;
        end
    end

    assign move_en   = move_en_q;
    assign step_tick = step_tick_q;
    assign dir       = dir_q;
    assign pos_reset = pos_reset_q;
    assign state     = state_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule

// File: tb/tb_pacman_game_ctrl.sv
// Scoreboard bench for pacman_game_ctrl with a 4-cycle step period.
// Observed vector: {state, pos_reset, win, lose, move_en, step_tick, dir}.
module tb_pacman_game_ctrl;

    localparam int TD = 4;

    localparam logic [1:0] SI = 2'b00;
    localparam logic [1:0] SP = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SL = 2'b11;
    localparam logic [1:0] DL = 2'b00;
    localparam logic [1:0] DR = 2'b10;
    localparam logic [1:0] DD = 2'b11;

    typedef struct {
        string      name;
        logic [8:0] v;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, ack, Left, Right, Up, Down, hit;
    logic [15:0] score;
    logic        move_en, step_tick, pos_reset, win, lose;
    logic [1:0]  dir, state;

    exp_t sb[$];
    exp_t e;
    int   passed = 0;
    int   total  = 0;

    pacman_game_ctrl #(
        .TICK_DIV  (TD),
        .WIN_SCORE (30),
        .CNT_W     (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ack       (ack),
        .Left      (Left),
        .Right     (Right),
        .Up        (Up),
        .Down      (Down),
        .score     (score),
        .hit       (hit),
        .move_en   (move_en),
        .dir       (dir),
        .step_tick (step_tick),
        .pos_reset (pos_reset),
        .state     (state),
        .win       (win),
        .lose      (lose)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] mk(logic [1:0] st, logic pr, logic w,
                                      logic l, logic me, logic tk,
                                      logic [1:0] d);
        return {st, pr, w, l, me, tk, d};
    endfunction

    function automatic logic [8:0] obs();
        return {state, pos_reset, win, lose, move_en, step_tick, dir};
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 0; ack = 0; hit = 0; score = 0;
        Left = 0; Right = 0; Up = 0; Down = 0;
        sb.push_back('{"reset_async", mk(SI, 1, 0, 0, 0, 0, DL)});
        sb.push_back('{"reset_held", mk(SI, 1, 0, 0, 0, 0, DL)});
        sb.push_back('{"init_idle", mk(SI, 1, 0, 0, 0, 0, DL)});
        #3;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) @(posedge clk);
            if (k == 2) begin
                @(negedge clk); reset = 1'b0;
                @(posedge clk);
            end
            #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
        end
    endtask

    task automatic test_move();
        for (int k = 0; k <= 12; k++) begin
            logic s;
            s = (k > 0) && (k % TD == 0);
            sb.push_back('{$sformatf("move_c%0d", k),
                mk(SP, 0, 0, 0, s, s, (k >= TD) ? DR : DL)});
        end
        @(negedge clk); start = 1; Right = 1;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
            start = 0;
        end
    endtask

    task automatic test_multi_button();
        Right = 0; Left = 1; Up = 1;
        for (int k = 1; k <= 12; k++) begin
            logic s;
            s = (k % TD == 0);
            sb.push_back('{$sformatf("multi_c%0d", k),
                mk(SP, 0, 0, 0, 0, s, DR)});
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
        end
        Left = 0; Up = 0;
    endtask

    task automatic test_win();
        sb.push_back('{"score29_play", mk(SP, 0, 0, 0, 0, 0, DR)});
        sb.push_back('{"score30_win", mk(SW, 0, 1, 0, 0, 0, DR)});
        sb.push_back('{"win_hold1", mk(SW, 0, 1, 0, 0, 0, DR)});
        sb.push_back('{"win_hold2", mk(SW, 0, 1, 0, 0, 0, DR)});
        sb.push_back('{"win_ack_init", mk(SI, 1, 0, 0, 0, 0, DR)});
        sb.push_back('{"init_after_ack", mk(SI, 1, 0, 0, 0, 0, DR)});
        score = 16'd29;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
            if (k == 0) score = 16'd30;
            if (k == 3) ack = 1;
            if (k == 4) begin ack = 0; score = 0; end
        end
    endtask

    task automatic test_priority();
        sb.push_back('{"prio_play", mk(SP, 0, 0, 0, 0, 0, DR)});
        sb.push_back('{"prio_win_over_hit", mk(SW, 0, 1, 0, 0, 0, DR)});
        sb.push_back('{"prio_ack_init", mk(SI, 1, 0, 0, 0, 0, DR)});
        sb.push_back('{"prio_play2", mk(SP, 0, 0, 0, 0, 0, DR)});
        sb.push_back('{"hit_lose", mk(SL, 0, 0, 1, 0, 0, DR)});
        sb.push_back('{"lose_hold", mk(SL, 0, 0, 1, 0, 0, DR)});
        start = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
            case (k)
                0: begin start = 0; hit = 1; score = 16'd30; end
                1: ack = 1;
                2: begin ack = 0; score = 16'd5; start = 1; end
                3: start = 0;
                default: ;
            endcase
        end
    endtask

    task automatic test_start_ack();
        sb.push_back('{"lose_start_ignored", mk(SL, 0, 0, 1, 0, 0, DR)});
        sb.push_back('{"start_ack_init", mk(SI, 1, 0, 0, 0, 0, DR)});
        sb.push_back('{"start_ack_play", mk(SP, 0, 0, 0, 0, 0, DR)});
        sb.push_back('{"start_ack_play2", mk(SP, 0, 0, 0, 0, 0, DR)});
        hit = 0; start = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
            if (k == 0) ack = 1;
            if (k == 2) begin start = 0; ack = 0; end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); reset = 1;
        @(negedge clk); reset = 0; Down = 1; start = 1;
        for (int k = 0; k <= 6; k++) begin
            logic s;
            s = (k == TD);
            sb.push_back('{$sformatf("down_c%0d", k),
                mk(SP, 0, 0, 0, s, s, (k >= TD) ? DD : DL)});
        end
        sb.push_back('{"async_reset_mid", mk(SI, 1, 0, 0, 0, 0, DL)});
        for (int k = 0; k <= TD; k++) begin
            logic s;
            s = (k == TD);
            sb.push_back('{$sformatf("restart_c%0d", k),
                mk(SP, 0, 0, 0, s, s, s ? DD : DL)});
        end
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
            start = 0;
        end
        #3 reset = 1;
        #1;
        e = sb.pop_front(); total++;
        if (obs() !== e.v)
            $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
        else passed++;
        @(negedge clk); reset = 0; start = 1;
        for (int k = 0; k <= TD; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
            start = 0;
        end
        Down = 0;
    endtask

    task automatic test_exit_on_wrap();
        sb.push_back('{"wrapx_c1", mk(SP, 0, 0, 0, 0, 0, DD)});
        sb.push_back('{"wrapx_c2", mk(SP, 0, 0, 0, 0, 0, DD)});
        sb.push_back('{"wrapx_c3", mk(SP, 0, 0, 0, 0, 0, DD)});
        sb.push_back('{"exit_on_wrap", mk(SW, 0, 1, 0, 0, 0, DD)});
        sb.push_back('{"win_no_strobe", mk(SW, 0, 1, 0, 0, 0, DD)});
        sb.push_back('{"wrapx_ack_init", mk(SI, 1, 0, 0, 0, 0, DD)});
        Right = 1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            e = sb.pop_front(); total++;
            if (obs() !== e.v)
                $display("FAIL %s: got %b want %b", e.name, obs(), e.v);
            else passed++;
            if (k == 3) score = 16'd30;
            if (k == 5) ack = 1;
        end
        ack = 0; score = 0; Right = 0;
    endtask

    initial begin
        test_reset();
        test_move();
        test_multi_button();
        test_win();
        test_priority();
        test_start_ack();
        test_async_reset();
        test_exit_on_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
